// File: rtl/mult_dispatch.sv
// mult_dispatch -- consumer end of the multiply operand queues.
//
// Pops one operand pair from the multiplicand (q1) and multiplier (q2)
// queues, launches the Booth multiplier, captures its 2*WIDTH-bit product
// and writes the product back to the register file (LO word, then HI word).
// While a multiply is in flight, stall holds off the CPU's own register writes.
//
// Build option:
//   MULT_DISPATCH_HI_EN  defined   -> LO and HI words are both written
//                        undefined -> only the LO word is written
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   q1_empty, q1_data     multiplicand queue flag / show-ahead head data
//   q2_empty, q2_data     multiplier queue flag / show-ahead head data
//   pop                   one-cycle pop strobe to both queues
//   start                 one-cycle start strobe to the multiplier
//   mc, mp                registered operands to the multiplier
//   busy_m, prod          multiplier busy flag and product
//   wr_en, wr_addr, wr_data  register-file write port
//   stall                 high whenever the dispatcher is not idle
//   done_cnt              completed multiplies (wraps)
//   desync                sticky: queues disagreed on emptiness while idle
`timescale 1ns/1ps
module mult_dispatch #(
    parameter int         WIDTH   = 32,
    parameter logic [4:0] LO_REG  = 5'd26,
    parameter logic [4:0] HI_REG  = 5'd27,
    parameter int         BUSY_TO = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               q1_empty,
    input  logic               q2_empty,
    input  logic [WIDTH-1:0]   q1_data,
    input  logic [WIDTH-1:0]   q2_data,
    output logic               pop,
    output logic               start,
    output logic [WIDTH-1:0]   mc,
    output logic [WIDTH-1:0]   mp,
    input  logic               busy_m,
    input  logic [2*WIDTH-1:0] prod,
    output logic               wr_en,
    output logic [4:0]         wr_addr,
    output logic [WIDTH-1:0]   wr_data,
    output logic               stall,
    output logic [7:0]         done_cnt,
    output logic               desync
);

    localparam int CW = $clog2(BUSY_TO + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_POP       = 3'd1,
        S_LAUNCH    = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_WR_LO     = 3'd5,
        S_WR_HI     = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mc_q, mc_d;
    logic [WIDTH-1:0]     mp_q, mp_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [7:0]           done_q, done_d;
    logic                 desync_q, desync_d;
    logic                 pop_q, pop_d;
    logic                 start_q, start_d;
    logic                 stall_q, stall_d;
    logic                 wr_en_q, wr_en_d;
    logic [4:0]           wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]     wr_data_q, wr_data_d;

    // Next-state and datapath capture logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mc_d     = mc_q;
        mp_d     = mp_q;
        prod_d   = prod_q;
        done_d   = done_q;
        desync_d = desync_q;
        case (state_q)
            S_IDLE: begin
                // Disagreement is only recorded; it never blocks dispatch.
                if (q1_empty != q2_empty) begin
                    desync_d = 1'b1;
                end else begin
                    desync_d = desync_q;
                end
                if (!q1_empty && !q2_empty) begin
                    state_d = S_POP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_POP: begin
                mc_d    = q1_data;
                mp_d    = q2_data;
                state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // A multiplier that never raises busy (zero-cycle multiply)
                // is released by the timeout.
                if (busy_m) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(BUSY_TO)) begin
                        state_d = S_WAIT_DONE;
                    end else begin
                        state_d = S_WAIT_BUSY;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!busy_m) begin
                    prod_d  = prod;
                    state_d = S_WR_LO;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WR_LO: begin
`ifdef MULT_DISPATCH_HI_EN
                state_d = S_WR_HI;
`else
                done_d  = done_q + 8'd1;
                state_d = S_IDLE;
`endif
            end
            S_WR_HI: begin
                done_d  = done_q + 8'd1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every strobe is a flop that is
    // high exactly while the registered state is in its active state.
    always_comb begin
        pop_d     = (state_d == S_POP);
        start_d   = (state_d == S_LAUNCH);
        stall_d   = (state_d != S_IDLE);
        wr_en_d   = 1'b0;
        wr_addr_d = 5'd0;
        wr_data_d = '0;
        case (state_d)
            S_WR_LO: begin
                // prod_d is the value entering prod_q on this edge.
                wr_en_d   = 1'b1;
                wr_addr_d = LO_REG;
                wr_data_d = prod_d[WIDTH-1:0];
            end
            S_WR_HI: begin
                // Unreachable unless the high-word state is built in.
                wr_en_d   = 1'b1;
                wr_addr_d = HI_REG;
                wr_data_d = prod_d[2*WIDTH-1:WIDTH];
            end
            default: begin
                wr_en_d   = 1'b0;
                wr_addr_d = 5'd0;
                wr_data_d = '0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mc_q      <= '0;
            mp_q      <= '0;
            prod_q    <= '0;
            done_q    <= 8'd0;
            desync_q  <= 1'b0;
            pop_q     <= 1'b0;
            start_q   <= 1'b0;
            stall_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mc_q      <= mc_d;
            mp_q      <= mp_d;
            prod_q    <= prod_d;
            done_q    <= done_d;
            desync_q  <= desync_d;
            pop_q     <= pop_d;
            start_q   <= start_d;
            stall_q   <= stall_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign pop      = pop_q;
    assign start    = start_q;
    assign mc       = mc_q;
    assign mp       = mp_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign stall    = stall_q;
    assign done_cnt = done_q;
    assign desync   = desync_q;

endmodule

// File: tb/tb_mult_dispatch.sv
// Testbench for mult_dispatch: randomized operand queues and multiplier
// timing, checked each cycle against a transaction-level timeline model.
`timescale 1ns/1ps
module tb_mult_dispatch;

    localparam int W = 32;
`ifdef MULT_DISPATCH_HI_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           q1_empty, q2_empty;
    logic [W-1:0]   q1_data, q2_data;
    logic           pop, start;
    logic [W-1:0]   mc, mp;
    logic           busy_m;
    logic [2*W-1:0] prod;
    logic           wr_en;
    logic [4:0]     wr_addr;
    logic [W-1:0]   wr_data;
    logic           stall;
    logic [7:0]     done_cnt;
    logic           desync;

    mult_dispatch dut (
        .clk(clk), .rst(rst),
        .q1_empty(q1_empty), .q2_empty(q2_empty),
        .q1_data(q1_data), .q2_data(q2_data),
        .pop(pop), .start(start), .mc(mc), .mp(mp),
        .busy_m(busy_m), .prod(prod),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .stall(stall), .done_cnt(done_cnt), .desync(desync)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] q1_q[$];
    logic [31:0] q2_q[$];

    // Timeline model of the transaction in flight (cycle numbers, -1 = none).
    bit          tx_active, rst_req, rst_prev, desync_pend, exp_desync;
    int          exp_pop_c, exp_start_c, exp_lo_c, exp_hi_c, idle_from;
    int          busy_rise, busy_fall, prod_ok_c;
    int          exp_done;
    int          force_d = -1;
    int          force_l = -1;
    logic [31:0] cur_a, cur_b, exp_mc, exp_mp;
    logic [63:0] cur_prod;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        tx_active   = 1'b0;
        desync_pend = 1'b0;
        exp_desync  = 1'b0;
        exp_pop_c   = -1;
        exp_start_c = -1;
        exp_lo_c    = -1;
        exp_hi_c    = -1;
        idle_from   = -1;
        busy_rise   = -1;
        busy_fall   = -1;
        prod_ok_c   = -1;
        exp_done    = 0;
        exp_mc      = 32'd0;
        exp_mp      = 32'd0;
    endtask

    // Schedule one multiply accepted in the current (idle) cycle.
    task automatic accept();
        int s, d, l, n;
        s           = cyc + 2;
        exp_pop_c   = cyc + 1;
        exp_start_c = s;
        cur_a       = q1_q[0];
        cur_b       = q2_q[0];
        cur_prod    = 64'(cur_a) * 64'(cur_b);
        d = (force_d >= 0) ? force_d : int'($urandom_range(0, 4));
        l = (force_l > 0) ? force_l : int'($urandom_range(1, 6));
        if (d == 4) begin
            // Multiplier never raises busy: released by the 3-cycle timeout.
            busy_rise = -1;
            busy_fall = -1;
            prod_ok_c = s + 1;
            n         = s + 4;
        end else begin
            busy_rise = s + 1 + d;
            busy_fall = busy_rise + l;
            prod_ok_c = busy_fall;
            n         = busy_fall;
        end
        exp_lo_c  = n + 1;
        exp_hi_c  = HI_EN ? n + 2 : -1;
        idle_from = HI_EN ? n + 3 : n + 2;
        tx_active = 1'b1;
    endtask

    task automatic step();
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        @(posedge clk);
        cyc++;
        #1;
        if (rst_prev) begin
            model_reset();
        end else begin
            if (cyc - 1 == exp_pop_c) begin
                void'(q1_q.pop_front());
                void'(q2_q.pop_front());
            end
            if (desync_pend) exp_desync = 1'b1;
            desync_pend = 1'b0;
            if (tx_active && cyc == idle_from) begin
                tx_active = 1'b0;
                exp_done++;
            end
            if (cyc == exp_start_c) begin
                exp_mc = cur_a;
                exp_mp = cur_b;
            end
        end
        e_addr = 5'd0;
        e_data = 32'd0;
        if (cyc == exp_lo_c) begin
            e_addr = 5'd26;
            e_data = cur_prod[31:0];
        end else if (cyc == exp_hi_c) begin
            e_addr = 5'd27;
            e_data = cur_prod[63:32];
        end
        check_eq("pop",      64'(pop),      64'(cyc == exp_pop_c));
        check_eq("start",    64'(start),    64'(cyc == exp_start_c));
        check_eq("stall",    64'(stall),    64'(tx_active));
        check_eq("mc",       64'(mc),       64'(exp_mc));
        check_eq("mp",       64'(mp),       64'(exp_mp));
        check_eq("wr_en",    64'(wr_en),    64'(cyc == exp_lo_c || cyc == exp_hi_c));
        check_eq("wr_addr",  64'(wr_addr),  64'(e_addr));
        check_eq("wr_data",  64'(wr_data),  64'(e_data));
        check_eq("done_cnt", 64'(done_cnt), 64'(8'(exp_done)));
        check_eq("desync",   64'(desync),   64'(exp_desync));
        // Drive this cycle's inputs.
        rst      = rst_req;
        rst_prev = rst_req;
        q1_empty = (q1_q.size() == 0);
        q2_empty = (q2_q.size() == 0);
        q1_data  = q1_empty ? $urandom : q1_q[0];
        q2_data  = q2_empty ? $urandom : q2_q[0];
        busy_m   = (cyc >= busy_rise) && (cyc < busy_fall);
        prod     = (prod_ok_c >= 0 && cyc >= prod_ok_c) ? cur_prod : {$urandom, $urandom};
        if (!rst_req && !tx_active) begin
            if (q1_empty != q2_empty) desync_pend = 1'b1;
            if (!q1_empty && !q2_empty) accept();
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        q1_q.push_back(a);
        q2_q.push_back(b);
    endtask

    task automatic run_idle(input int max_cyc);
        bit idle_s;
        idle_s = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (!tx_active && (q1_q.size() == 0 || q2_q.size() == 0)) begin
                idle_s = 1'b1;
                break;
            end
            step();
        end
        if (!idle_s) check_eq("drain_timeout", 64'(idle_s), 64'd1);
    endtask

    initial begin
        bit reached;
        rst_req  = 1'b1;
        rst_prev = 1'b1;
        rst      = 1'b1;
        q1_empty = 1'b1;
        q2_empty = 1'b1;
        q1_data  = 32'd0;
        q2_data  = 32'd0;
        busy_m   = 1'b0;
        prod     = 64'd0;
        model_reset();
        repeat (3) step();
        rst_req = 1'b0;
        // Idle with empty queues.
        repeat (20) step();

        // 7 x 6 with a 32-cycle multiply.
        force_d = 0;
        force_l = 32;
        push(32'd7, 32'd6);
        run_idle(200);
        force_d = -1;
        force_l = -1;

        // All-ones multiplicand: carries into the high word.
        push(32'hFFFF_FFFF, 32'h0000_0002);
        run_idle(100);

        // Two pairs back-to-back.
        push(32'd11, 32'd13);
        push(32'h8000_0001, 32'h7FFF_FFFF);
        run_idle(200);

        // Reset while waiting for the multiplier to finish.
        force_d = 1;
        force_l = 32;
        push(32'd5, 32'd9);
        reached = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tx_active && busy_rise >= 0 && cyc >= busy_rise + 4) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) check_eq("reach_wait_done", 64'(reached), 64'd1);
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        repeat (5) step();
        force_d = -1;
        force_l = -1;

        // Desync: q1 non-empty, q2 empty, then q2 fills.
        q1_q.push_back(32'd3);
        repeat (6) step();
        q2_q.push_back(32'd4);
        run_idle(100);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) push($urandom, $urandom);
            step();
        end
        run_idle(1000);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
